// File: rtl/frac_baud_generator_pkg.sv
// Shared definitions for the fractional baud generator.
// Holds default divisor widths, the oversample ratio and the standard
// divisor settings for a 50 MHz clock with x16 oversampling.
`timescale 1ns/1ps
package frac_baud_generator_pkg;

  localparam int DIV_INT_W_DEF  = 16;
  localparam int FRAC_W_DEF     = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Divisor setting: integer part plus fraction in units of 1/256.
  typedef struct packed {
    logic [DIV_INT_W_DEF-1:0] div_int;
    logic [FRAC_W_DEF-1:0]    div_frac;
  } baud_div_t;

  // 50 MHz / (16 * baud)
  localparam baud_div_t DIV_9600   = '{div_int: 16'd325, div_frac: 8'd133};
  localparam baud_div_t DIV_19200  = '{div_int: 16'd162, div_frac: 8'd195};
  localparam baud_div_t DIV_115200 = '{div_int: 16'd27,  div_frac: 8'd32};
  localparam baud_div_t DIV_256000 = '{div_int: 16'd12,  div_frac: 8'd53};

endpackage

// File: rtl/frac_baud_generator_baud_os_counter.sv
// Oversample counter for the baud generator.
// Counts sample ticks modulo OVERSAMPLE and decodes the bit-rate and
// mid-bit enables, registered so they line up with the registered sample
// enable produced by the top.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   tick_i       : sample tick (wrap of the divisor counter)
//   sync_i       : phase restart; clears the count, suppresses enables
//   bit_en_o     : high for one cycle on the last tick of a bit
//   mid_en_o     : high for one cycle on the middle tick of a bit
`timescale 1ns/1ps
module baud_os_counter
  import frac_baud_generator_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sync_i,
  output logic bit_en_o,
  output logic mid_en_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic            bit_q, bit_d;
  logic            mid_q, mid_d;

  always_comb begin
    os_cnt_d = os_cnt_q;
    bit_d    = 1'b0;
    mid_d    = 1'b0;
    if (sync_i) begin
      os_cnt_d = '0;
    end else if (tick_i) begin
      bit_d    = (os_cnt_q == OS_LAST);
      mid_d    = (os_cnt_q == OS_MID);
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      os_cnt_q <= '0;
      bit_q    <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      os_cnt_q <= os_cnt_d;
      bit_q    <= bit_d;
      mid_q    <= mid_d;
    end
  end

  assign bit_en_o = bit_q;
  assign mid_en_o = mid_q;

endmodule

// File: rtl/frac_baud_generator.sv
// Runtime-programmable fractional baud-tick generator.
// Divides clk_i by div_int.div_frac to produce the oversample enable, and
// derives bit-rate and mid-bit enables from it. A new divisor is staged in
// a shadow register and takes effect at the next period boundary (or at
// once on sync_i) so a period is never cut short by a reconfiguration.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   en_i               : run; low freezes counters and silences enables
//   sync_i             : phase restart (start-bit edge from RX)
//   cfg_we_i           : write strobe for cfg_div_int_i / cfg_div_frac_i
//   cfg_pending_o      : a written divisor is waiting to be applied
//   cfg_err_o          : one-cycle pulse when a write is rejected (div_int < 2)
//   sample_en_o        : oversample enable
//   bit_en_o, mid_en_o : bit and mid-bit enables, coincident with sample_en_o
`timescale 1ns/1ps
module frac_baud_generator
  import frac_baud_generator_pkg::*;
#(
  parameter int DIV_INT_W      = DIV_INT_W_DEF,
  parameter int FRAC_W         = FRAC_W_DEF,
  parameter int OVERSAMPLE     = OVERSAMPLE_DEF,
  parameter int RESET_DIV_INT  = int'(DIV_9600.div_int),
  parameter int RESET_DIV_FRAC = int'(DIV_9600.div_frac)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 sync_i,
  input  logic                 cfg_we_i,
  input  logic [DIV_INT_W-1:0] cfg_div_int_i,
  input  logic [FRAC_W-1:0]    cfg_div_frac_i,
  output logic                 cfg_pending_o,
  output logic                 cfg_err_o,
  output logic                 sample_en_o,
  output logic                 bit_en_o,
  output logic                 mid_en_o
);

  localparam int CNT_W = DIV_INT_W + 1;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAC_W-1:0]    acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [DIV_INT_W-1:0] div_int_q, div_int_d;
  logic [FRAC_W-1:0]    div_frac_q, div_frac_d;
  logic [DIV_INT_W-1:0] shadow_int_q, shadow_int_d;
  logic [FRAC_W-1:0]    shadow_frac_q, shadow_frac_d;
  logic                 pending_q, pending_d;
  logic                 err_q, err_d;
  logic                 sample_q, sample_d;

  logic [CNT_W-1:0]     period_last;
  logic [FRAC_W-1:0]    next_frac;
  logic [FRAC_W:0]      acc_sum;
  logic                 cfg_ok;
  logic                 wrap;

  always_comb begin
    // Current period is div_int plus the carry earned at the previous wrap.
    period_last = {1'b0, div_int_q} + {{DIV_INT_W{1'b0}}, carry_q} - CNT_W'(1);
    cfg_ok      = cfg_we_i && (cfg_div_int_i >= DIV_INT_W'(2));
    wrap        = en_i && !sync_i && (cnt_q == period_last);

    // The carry belongs to the period being started, so it is built from
    // whichever fraction that period will use.
    next_frac   = pending_q ? shadow_frac_q : div_frac_q;
    acc_sum     = {1'b0, acc_q} + {1'b0, next_frac};

    cnt_d         = cnt_q;
    acc_d         = acc_q;
    carry_d       = carry_q;
    div_int_d     = div_int_q;
    div_frac_d    = div_frac_q;
    shadow_int_d  = shadow_int_q;
    shadow_frac_d = shadow_frac_q;
    pending_d     = pending_q;
    err_d         = cfg_we_i && !cfg_ok;
    sample_d      = wrap;

    if (sync_i) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      if (cfg_ok) begin
        div_int_d  = cfg_div_int_i;
        div_frac_d = cfg_div_frac_i;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        div_int_d  = shadow_int_q;
        div_frac_d = shadow_frac_q;
        pending_d  = 1'b0;
      end
    end else begin
      if (wrap) begin
        cnt_d   = '0;
        acc_d   = acc_sum[FRAC_W-1:0];
        carry_d = acc_sum[FRAC_W];
        if (pending_q) begin
          div_int_d  = shadow_int_q;
          div_frac_d = shadow_frac_q;
          pending_d  = 1'b0;
        end
      end else if (en_i) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // A write landing on a wrap stages behind the value applied above.
      if (cfg_ok) begin
        shadow_int_d  = cfg_div_int_i;
        shadow_frac_d = cfg_div_frac_i;
        pending_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      div_int_q     <= DIV_INT_W'(RESET_DIV_INT);
      div_frac_q    <= FRAC_W'(RESET_DIV_FRAC);
      shadow_int_q  <= '0;
      shadow_frac_q <= '0;
      pending_q     <= 1'b0;
      err_q         <= 1'b0;
      sample_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
      div_int_q     <= div_int_d;
      div_frac_q    <= div_frac_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      pending_q     <= pending_d;
      err_q         <= err_d;
      sample_q      <= sample_d;
    end
  end

  baud_os_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick_i   (wrap),
    .sync_i   (sync_i),
    .bit_en_o (bit_en_o),
    .mid_en_o (mid_en_o)
  );

  assign cfg_pending_o = pending_q;
  assign cfg_err_o     = err_q;
  assign sample_en_o   = sample_q;

endmodule

// File: tb/tb_frac_baud_generator.sv
`timescale 1ns/1ps
module tb_frac_baud_generator;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic        we;
  logic [15:0] cdi;
  logic [7:0]  cdf;
  logic        cfg_pending_o;
  logic        cfg_err_o;
  logic        sample_en_o;
  logic        bit_en_o;
  logic        mid_en_o;

  always #5 clk = ~clk;

  frac_baud_generator dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .sync_i         (sync),
    .cfg_we_i       (we),
    .cfg_div_int_i  (cdi),
    .cfg_div_frac_i (cdf),
    .cfg_pending_o  (cfg_pending_o),
    .cfg_err_o      (cfg_err_o),
    .sample_en_o    (sample_en_o),
    .bit_en_o       (bit_en_o),
    .mid_en_o       (mid_en_o)
  );

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    n_sample = 0;
  // Scoreboard: expected pulse cycles for sample_en, bit_en, mid_en.
  int    exp_q[3][$];
  string nm[3] = '{"sample_en", "bit_en", "mid_en"};

  // Expected pulse schedule for a run of periods starting with cnt = 0 at
  // cycle t0; the k-th period gains the carry floor((k-1)f/256)-floor((k-2)f/256).
  task automatic push_sched(input int t0, input int di, input int df,
                            input int tick0, input int limit);
    int t, tick, k, carry;
    t = t0; tick = tick0; k = 1;
    forever begin
      carry = (k == 1) ? 0 : (((k - 1) * df) / 256 - ((k - 2) * df) / 256);
      t = t + di + carry;
      if (t > limit) break;
      exp_q[0].push_back(t);
      tick++;
      if (tick % OS == 0) exp_q[1].push_back(t);
      if (tick % OS == OS / 2) exp_q[2].push_back(t);
      k++;
    end
  endtask

  task automatic observe();
    logic [2:0] v;
    int m;
    v = {mid_en_o, bit_en_o, sample_en_o};
    if (sample_en_o) n_sample++;
    for (int i = 0; i < 3; i++) begin
      while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
        m = exp_q[i].pop_front();
        checks++; failures++;
        $display("FAIL %s missing: cycle %0d got 0, required 1", nm[i], m);
      end
      if (v[i]) begin
        checks++;
        if (exp_q[i].size() == 0 || exp_q[i][0] !== cyc) begin
          failures++;
          $display("FAIL %s unexpected: pulse at cycle %0d, next required at %0d",
                   nm[i], cyc, (exp_q[i].size() > 0) ? exp_q[i][0] : -1);
        end else begin
          void'(exp_q[i].pop_front());
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic drain(input string tname);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() !== 0) begin
        failures++;
        $display("FAIL %s %s leftover: %0d pulses not seen, required 0", tname, nm[i], exp_q[i].size());
      end
      exp_q[i].delete();
    end
  endtask

  // Reset, load the divisor through sync+write (applies at once), then
  // release with en=1; the returning negedge is cycle 0.
  task automatic start(input int di, input int df);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sync = 1'b0; we = 1'b0; cdi = '0; cdf = '0;
    @(negedge clk);
    rst = 1'b0; we = 1'b1; sync = 1'b1; cdi = 16'(di); cdf = 8'(df);
    @(negedge clk);
    we = 1'b0; sync = 1'b0; en = 1'b1;
    cyc = 0; n_sample = 0;
    observe();
    checks++;
    if (cfg_pending_o !== 1'b0) begin
      failures++;
      $display("FAIL start_pending: got %b, required 0", cfg_pending_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sync = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; cyc = 0;
    observe();
    checks++;
    if ({sample_en_o, bit_en_o, mid_en_o, cfg_pending_o, cfg_err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {sample_en_o, bit_en_o, mid_en_o, cfg_pending_o, cfg_err_o});
    end
    // 325.133: periods 325, 325, 326
    push_sched(0, 325, 133, 0, 1000);
    run_to(1000);
    drain("reset_div");
  endtask

  task automatic test_int_div();
    start(4, 0);
    push_sched(0, 4, 0, 0, 200);
    run_to(200);
    drain("int_div");
  endtask

  task automatic test_frac_div();
    start(4, 128);
    push_sched(0, 4, 128, 0, 1151);
    run_to(1151);
    checks++;
    if (n_sample !== 256) begin
      failures++;
      $display("FAIL frac_count: got %0d sample_en in 1152 cycles, required 256", n_sample);
    end
    drain("frac_div");
  endtask

  task automatic test_cfg_apply();
    logic exp_p;
    start(10, 0);
    push_sched(0, 10, 0, 0, 10);
    push_sched(10, 6, 0, 1, 80);
    run_to(3);
    we = 1'b1; cdi = 16'd6; cdf = 8'd0;
    step();
    we = 1'b0;
    while (cyc <= 12) begin
      exp_p = (cyc >= 4 && cyc <= 9);
      checks++;
      if (cfg_pending_o !== exp_p) begin
        failures++;
        $display("FAIL cfg_pending cycle %0d: got %b, required %b", cyc, cfg_pending_o, exp_p);
      end
      step();
    end
    run_to(80);
    drain("cfg_apply");
  endtask

  task automatic test_cfg_reject();
    start(10, 0);
    push_sched(0, 10, 0, 0, 60);
    run_to(3);
    we = 1'b1; cdi = 16'd1; cdf = 8'd5;
    step();
    we = 1'b0;
    checks++;
    if ({cfg_err_o, cfg_pending_o} !== 2'b10) begin
      failures++;
      $display("FAIL cfg_reject err/pending: got %b, required 10", {cfg_err_o, cfg_pending_o});
    end
    step();
    checks++;
    if ({cfg_err_o, cfg_pending_o} !== 2'b00) begin
      failures++;
      $display("FAIL cfg_reject after: got %b, required 00", {cfg_err_o, cfg_pending_o});
    end
    run_to(60);
    drain("cfg_reject");
  endtask

  // Overwrite before apply, then a write landing on the wrap cycle.
  task automatic test_back_to_back();
    start(10, 0);
    push_sched(0, 10, 0, 0, 10);
    push_sched(10, 6, 0, 1, 16);
    push_sched(16, 8, 0, 2, 120);
    run_to(2);
    we = 1'b1; cdi = 16'd12; cdf = 8'd0;
    step();
    cdi = 16'd6;
    step();
    we = 1'b0;
    run_to(9);
    we = 1'b1; cdi = 16'd8;
    step();
    we = 1'b0;
    checks++;
    if (cfg_pending_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b pending after wrap write: got %b, required 1", cfg_pending_o);
    end
    run_to(16);
    checks++;
    if (cfg_pending_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b pending after apply: got %b, required 0", cfg_pending_o);
    end
    run_to(120);
    drain("back_to_back");
  endtask

  task automatic test_sync();
    start(10, 0);
    push_sched(0, 10, 0, 0, 17);
    push_sched(18, 10, 0, 0, 37);
    push_sched(38, 10, 0, 0, 200);
    run_to(17);
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (sample_en_o !== 1'b0) begin
      failures++;
      $display("FAIL sync mid-period: sample_en got %b, required 0", sample_en_o);
    end
    run_to(37);
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (sample_en_o !== 1'b0) begin
      failures++;
      $display("FAIL sync on wrap: sample_en got %b, required 0", sample_en_o);
    end
    run_to(200);
    drain("sync");
  endtask

  task automatic test_enable_hold();
    start(10, 0);
    push_sched(0, 10, 0, 0, 14);
    push_sched(30, 10, 0, 1, 40);
    push_sched(40, 5, 0, 2, 150);
    run_to(15);
    en = 1'b0;
    run_to(20);
    we = 1'b1; cdi = 16'd5; cdf = 8'd0;
    step();
    we = 1'b0;
    checks++;
    if (cfg_pending_o !== 1'b1) begin
      failures++;
      $display("FAIL en_low write pending: got %b, required 1", cfg_pending_o);
    end
    run_to(35);
    en = 1'b1;
    run_to(39);
    checks++;
    if (cfg_pending_o !== 1'b1) begin
      failures++;
      $display("FAIL en_hold pending before wrap: got %b, required 1", cfg_pending_o);
    end
    step();
    checks++;
    if (cfg_pending_o !== 1'b0) begin
      failures++;
      $display("FAIL en_hold pending after wrap: got %b, required 0", cfg_pending_o);
    end
    run_to(150);
    drain("enable_hold");
  endtask

  task automatic test_reset_midrun();
    start(5, 0);
    push_sched(0, 5, 0, 0, 22);
    run_to(22);
    drain("pre_reset");
    we = 1'b1; cdi = 16'd9; cdf = 8'd0;
    step();
    we = 1'b0;
    checks++;
    if (cfg_pending_o !== 1'b1) begin
      failures++;
      $display("FAIL midrun pending before reset: got %b, required 1", cfg_pending_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc = 0;
    observe();
    checks++;
    if ({sample_en_o, bit_en_o, mid_en_o, cfg_pending_o, cfg_err_o} !== 5'b0) begin
      failures++;
      $display("FAIL midrun reset outputs: got %b, required 00000",
               {sample_en_o, bit_en_o, mid_en_o, cfg_pending_o, cfg_err_o});
    end
    push_sched(0, 325, 133, 0, 700);
    run_to(700);
    drain("reset_midrun");
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; we = 1'b0; cdi = '0; cdf = '0;
    test_reset();
    test_int_div();
    test_frac_div();
    test_cfg_apply();
    test_cfg_reject();
    test_back_to_back();
    test_sync();
    test_enable_hold();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
